hazard_stall: RTL and testbench

HAZARD_STALL -- requirements
Module: hazard_stall

---
 rtl/hazard_stall_pkg.sv | 13 +
 rtl/hazard_stall_sat_counter.sv | 26 ++
 rtl/hazard_stall.sv | 134 +++++++++++++
 tb/tb_hazard_stall.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

    // Memory-wait tracking states.
    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // ResultSrcE encoding that marks a load from data memory.
    localparam logic [1:0] RESULT_LOAD = 2'b01;

endpackage

// File: rtl/hazard_stall_sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    // Next value for an enabled cycle, holding at the ceiling instead of wrapping.
    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + WIDTH'(1);
    endfunction

    // Count enabled cycles; reset clears immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc)
            count <= sat_inc(count);
    end

endmodule

// File: rtl/hazard_stall.sv
// Hazard controller: load-use stalls, branch flushes, memory-miss stalls,
// a sticky memory timeout flag and three saturating performance counters.
module hazard_stall
    import hazard_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdE,
    input  logic [1:0]       ResultSrcE,
    input  logic [2:0]       RegWriteE,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] LoadStallCnt,
    output logic [CNT_W-1:0] FlushCnt,
    output logic [CNT_W-1:0] MemStallCnt
);

    // Wait counter only needs to reach TIMEOUT, then it parks there.
    localparam int                WAIT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_inc;
    logic              miss;
    logic              lu;
    logic              ms;
    logic              br_flush;
    logic              lu_stall;

    // A miss is a memory request the memory did not complete this cycle.
    assign miss     = MemReqM && !MemReadyM;
    assign lu       = (ResultSrcE == RESULT_LOAD) && (RegWriteE != 3'b000) && (RdE != 5'd0)
                      && ((Rs1D == RdE) || (Rs2D == RdE));
    // The first miss cycle stalls combinationally, before the FSM has moved.
    assign ms       = (state == MEM_WAIT) || ((state == IDLE) && miss);
    assign br_flush = !ms && PCSrcE;
    assign lu_stall = !ms && !PCSrcE && lu;
    assign wait_inc = wait_cnt + WAIT_W'(1);

    // Next-state logic: leave IDLE on a miss, return once the memory is ready.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (miss)      state_nxt = MEM_WAIT;
            MEM_WAIT: if (MemReadyM) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Stall/flush decode with priority memory stall > branch > load-use.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (ms) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (lu) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Wait counter restarts on entry to MEM_WAIT; the timeout flag latches once it hits TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt   <= '0;
            MemTimeout <= 1'b0;
        end else if ((state == IDLE) && miss) begin
            wait_cnt <= '0;
        end else if ((state == MEM_WAIT) && (wait_cnt != WAIT_MAX)) begin
            wait_cnt <= wait_inc;
            if (wait_inc == WAIT_MAX)
                MemTimeout <= 1'b1;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_load_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (lu_stall),
        .count (LoadStallCnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (br_flush),
        .count (FlushCnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_mem_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ms),
        .count (MemStallCnt)
    );

endmodule

// File: tb/tb_hazard_stall.sv
// Bench for hazard_stall: directed scenarios plus randomized traffic against a
// cycle-level reference model. Two instances share stimulus: one wide-counter,
// one 2-bit counter to exercise saturation.
module tb_hazard_stall;

    localparam int TO = 4;
    localparam int WA = 16;
    localparam int WB = 2;

    localparam logic [6:0] V_MS = 7'b1111001;
    localparam logic [6:0] V_BR = 7'b0000110;
    localparam logic [6:0] V_LU = 7'b1100010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic [4:0]    Rs1D = '0, Rs2D = '0, RdE = '0;
    logic [1:0]    ResultSrcE = '0;
    logic [2:0]    RegWriteE = '0;
    logic          PCSrcE = 1'b0, MemReqM = 1'b0, MemReadyM = 1'b0;

    logic          a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_fw, a_to;
    logic [WA-1:0] a_lsc, a_fc, a_msc;
    logic          b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_fw, b_to;
    logic [WB-1:0] b_lsc, b_fc, b_msc;

    hazard_stall #(.CNT_W(WA), .TIMEOUT(TO)) dut_a (
        .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .RegWriteE(RegWriteE), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(a_sf), .StallD(a_sd), .StallE(a_se), .StallM(a_sm),
        .FlushD(a_fd), .FlushE(a_fe), .FlushW(a_fw), .MemTimeout(a_to),
        .LoadStallCnt(a_lsc), .FlushCnt(a_fc), .MemStallCnt(a_msc)
    );

    hazard_stall #(.CNT_W(WB), .TIMEOUT(TO)) dut_b (
        .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .RegWriteE(RegWriteE), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(b_sf), .StallD(b_sd), .StallE(b_se), .StallM(b_sm),
        .FlushD(b_fd), .FlushE(b_fe), .FlushW(b_fw), .MemTimeout(b_to),
        .LoadStallCnt(b_lsc), .FlushCnt(b_fc), .MemStallCnt(b_msc)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: waiting flag, MEM_WAIT cycles since entry, raw event counts.
    bit m_wait = 0;
    bit m_to   = 0;
    int m_mw   = 0;
    int m_lsc  = 0;
    int m_fc   = 0;
    int m_msc  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Expected stall/flush vector {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}.
    function automatic logic [6:0] exp_vec();
        bit ms, lu;
        ms = m_wait || (MemReqM && !MemReadyM);
        lu = (ResultSrcE == 2'b01) && (RegWriteE != 0) && (RdE != 0) && (Rs1D == RdE || Rs2D == RdE);
        if (ms)     return V_MS;
        if (PCSrcE) return V_BR;
        if (lu)     return V_LU;
        return 7'b0;
    endfunction

    function automatic logic [6:0] vec_a();
        return {a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_fw};
    endfunction

    function automatic logic [6:0] vec_b();
        return {b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_fw};
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ".lsc_a"}, 32'(a_lsc), 32'(sat(m_lsc, WA)));
        chk({tag, ".fc_a"},  32'(a_fc),  32'(sat(m_fc, WA)));
        chk({tag, ".msc_a"}, 32'(a_msc), 32'(sat(m_msc, WA)));
        chk({tag, ".lsc_b"}, 32'(b_lsc), 32'(sat(m_lsc, WB)));
        chk({tag, ".fc_b"},  32'(b_fc),  32'(sat(m_fc, WB)));
        chk({tag, ".msc_b"}, 32'(b_msc), 32'(sat(m_msc, WB)));
        chk({tag, ".to_a"},  32'(a_to),  32'(m_to));
        chk({tag, ".to_b"},  32'(b_to),  32'(m_to));
    endtask

    // One clock: drive, check combinational outputs, clock, advance model, check state.
    task automatic cycle(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [1:0] rsrc, input logic [2:0] rw, input logic pc,
                         input logic req, input logic rdy, input string tag);
        logic [6:0] v;
        Rs1D = rs1; Rs2D = rs2; RdE = rd; ResultSrcE = rsrc; RegWriteE = rw;
        PCSrcE = pc; MemReqM = req; MemReadyM = rdy;
        #2;
        v = exp_vec();
        chk({tag, ".vec_a"}, 32'(vec_a()), 32'(v));
        chk({tag, ".vec_b"}, 32'(vec_b()), 32'(v));
        @(posedge clk);
        if (v == V_MS)      m_msc++;
        else if (v == V_BR) m_fc++;
        else if (v == V_LU) m_lsc++;
        if (m_wait) begin
            m_mw++;
            if (m_mw >= TO) m_to = 1;
            if (MemReadyM) m_wait = 0;
        end else if (MemReqM && !MemReadyM) begin
            m_wait = 1;
            m_mw   = 0;
        end
        #1;
        check_state(tag);
    endtask

    // Assert reset without a clock edge and check outputs collapse at once.
    task automatic apply_reset(input string tag);
        MemReqM = 1'b0; MemReadyM = 1'b0; PCSrcE = 1'b0; ResultSrcE = 2'b00;
        rst_n = 1'b0;
        #2;
        m_wait = 0; m_to = 0; m_mw = 0; m_lsc = 0; m_fc = 0; m_msc = 0;
        chk({tag, ".rst_vec_a"}, 32'(vec_a()), 32'h0);
        chk({tag, ".rst_vec_b"}, 32'(vec_b()), 32'h0);
        check_state({tag, ".rst"});
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        apply_reset("init");

        // Load-use on Rs1D: one stall cycle, counted once.
        cycle(5'd5, 5'd9, 5'd5, 2'b01, 3'd1, 1'b0, 1'b0, 1'b0, "lu");
        chk("lu.sf", 32'(a_lsc), 32'd1);
        cycle(5'd1, 5'd2, 5'd5, 2'b01, 3'd1, 1'b0, 1'b0, 1'b0, "lu_clear");
        chk("lu_clear.vec", 32'(vec_a()), 32'h0);

        // x0 destination never stalls; branch beats load-use.
        apply_reset("br");
        cycle(5'd0, 5'd0, 5'd0, 2'b01, 3'd1, 1'b0, 1'b0, 1'b0, "x0");
        chk("x0.lsc", 32'(a_lsc), 32'd0);
        cycle(5'd5, 5'd0, 5'd5, 2'b01, 3'd1, 1'b1, 1'b0, 1'b0, "br_lu");
        chk("br_lu.fc",  32'(a_fc),  32'd1);
        chk("br_lu.lsc", 32'(a_lsc), 32'd0);

        // Miss: three not-ready cycles then ready -> four stall cycles.
        apply_reset("miss");
        for (int i = 0; i < 3; i++)
            cycle(5'd0, 5'd0, 5'd0, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, "miss_wait");
        cycle(5'd0, 5'd0, 5'd0, 2'b00, 3'd0, 1'b0, 1'b1, 1'b1, "miss_done");
        chk("miss.msc_a", 32'(a_msc), 32'd4);
        chk("miss.msc_b", 32'(b_msc), 32'd3);
        cycle(5'd0, 5'd0, 5'd0, 2'b00, 3'd0, 1'b0, 1'b1, 1'b1, "miss_idle");
        chk("miss_idle.vec", 32'(vec_a()), 32'h0);

        // Timeout: six not-ready cycles, flag stays after the memory answers.
        apply_reset("to");
        for (int i = 0; i < 6; i++)
            cycle(5'd0, 5'd0, 5'd0, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, "to_wait");
        cycle(5'd0, 5'd0, 5'd0, 2'b00, 3'd0, 1'b0, 1'b1, 1'b1, "to_done");
        cycle(5'd0, 5'd0, 5'd0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, "to_idle");
        chk("to.sticky", 32'(a_to), 32'd1);

        // Reset in the middle of MEM_WAIT with MemReqM dropped.
        cycle(5'd0, 5'd0, 5'd0, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, "rw_enter");
        cycle(5'd0, 5'd0, 5'd0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, "rw_hold");
        chk("rw_hold.vec", 32'(vec_a()), 32'(V_MS));
        apply_reset("rw");
        cycle(5'd0, 5'd0, 5'd0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, "rw_after");

        // Saturation: five load-use cycles.
        apply_reset("sat");
        for (int i = 0; i < 5; i++)
            cycle(5'd7, 5'd7, 5'd7, 2'b01, 3'd4, 1'b0, 1'b0, 1'b0, "sat_lu");
        chk("sat.lsc_b", 32'(b_lsc), 32'd3);
        chk("sat.lsc_a", 32'(a_lsc), 32'd5);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(199) == 0) begin
                apply_reset("rnd");
            end else begin
                cycle(5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
                      2'($urandom_range(3)), 3'($urandom_range(7)),
                      ($urandom_range(7) == 0), 1'($urandom_range(1)),
                      ($urandom_range(2) == 0), "rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
